// File: rtl/rv_trace_pkg.sv
// rtl/rv_trace_pkg.sv - shared types for the retire-trace sink
package rv_trace_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic            mem_wrt;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/rv_retire_trace_sink_if.sv
// rtl/rv_retire_trace_sink_if.sv - retire, store and trace-stream signals
interface rv_retire_trace_sink_if #(
  parameter int XLEN = 32
);

  logic            update_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] instr_i;
  logic [4:0]      reg_addr_i;
  logic [XLEN-1:0] reg_data_i;
  logic            mem_wrt_i;
  logic [XLEN-1:0] mem_addr_i;
  logic [XLEN-1:0] mem_data_i;

  logic            trace_valid_o;
  logic            trace_ready_i;
  logic [XLEN-1:0] trace_pc_o;
  logic [XLEN-1:0] trace_instr_o;
  logic [4:0]      trace_rd_o;
  logic [XLEN-1:0] trace_rd_data_o;
  logic            trace_mem_wrt_o;
  logic [XLEN-1:0] trace_mem_addr_o;
  logic [XLEN-1:0] trace_mem_data_o;

  modport master (
    output update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
    output mem_wrt_i, mem_addr_i, mem_data_i, trace_ready_i,
    input  trace_valid_o, trace_pc_o, trace_instr_o, trace_rd_o, trace_rd_data_o,
    input  trace_mem_wrt_o, trace_mem_addr_o, trace_mem_data_o
  );

  modport slave (
    input  update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
    input  mem_wrt_i, mem_addr_i, mem_data_i, trace_ready_i,
    output trace_valid_o, trace_pc_o, trace_instr_o, trace_rd_o, trace_rd_data_o,
    output trace_mem_wrt_o, trace_mem_addr_o, trace_mem_data_o
  );

endinterface

// File: rtl/rv_trace_fifo.sv
// rtl/rv_trace_fifo.sv - synchronous FIFO of trace records with flush
module rv_trace_fifo
  import rv_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  trace_rec_t push_rec,
  input  logic       pop,
  output trace_rec_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  trace_rec_t    mem [DEPTH];

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // A push into a full FIFO with a pop overwrites the slot being read out this cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_rec;
  end

endmodule

// File: rtl/rv_retire_trace_sink.sv
// rtl/rv_retire_trace_sink.sv - captures retire records with attached stores, drains on a stream
module rv_retire_trace_sink #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  rv_retire_trace_sink_if.slave bus,
  output logic [CNT_W-1:0]      retire_count_o,
  output logic [CNT_W-1:0]      drop_count_o,
  output logic                  overflow_o
);

  import rv_trace_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic            pend;
  logic [XLEN-1:0] pend_addr;
  logic [XLEN-1:0] pend_data;
  trace_rec_t      new_rec;
  trace_rec_t      head;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            drop;

  assign pop  = !empty && bus.trace_ready_i;
  assign push = !clear_i && bus.update_i && (!full || pop);
  assign drop = !clear_i && bus.update_i && full && !pop;

  always_comb begin
    new_rec         = '0;
    new_rec.pc      = bus.pc_i;
    new_rec.instr   = bus.instr_i;
    new_rec.rd      = bus.reg_addr_i;
    new_rec.rd_data = (bus.reg_addr_i == 5'd0) ? '0 : bus.reg_data_i;
    // A store retiring alongside the instruction beats any older latched store.
    if (bus.mem_wrt_i) begin
      new_rec.mem_wrt  = 1'b1;
      new_rec.mem_addr = bus.mem_addr_i;
      new_rec.mem_data = bus.mem_data_i;
    end else if (pend) begin
      new_rec.mem_wrt  = 1'b1;
      new_rec.mem_addr = pend_addr;
      new_rec.mem_data = pend_data;
    end
  end

  rv_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rstn_i),
    .flush    (clear_i),
    .push     (push),
    .push_rec (new_rec),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend           <= 1'b0;
      pend_addr      <= '0;
      pend_data      <= '0;
      retire_count_o <= '0;
      drop_count_o   <= '0;
      overflow_o     <= 1'b0;
    end else if (clear_i) begin
      pend           <= 1'b0;
      pend_addr      <= '0;
      pend_data      <= '0;
      retire_count_o <= '0;
      drop_count_o   <= '0;
      overflow_o     <= 1'b0;
    end else if (bus.update_i) begin
      // The latched store is consumed even when the record itself is dropped.
      pend           <= 1'b0;
      pend_addr      <= '0;
      pend_data      <= '0;
      retire_count_o <= retire_count_o + CNT_ONE;
      if (drop) begin
        drop_count_o <= drop_count_o + CNT_ONE;
        overflow_o   <= 1'b1;
      end
    end else if (bus.mem_wrt_i) begin
      pend      <= 1'b1;
      pend_addr <= bus.mem_addr_i;
      pend_data <= bus.mem_data_i;
    end
  end

  assign bus.trace_valid_o    = !empty;
  assign bus.trace_pc_o       = head.pc;
  assign bus.trace_instr_o    = head.instr;
  assign bus.trace_rd_o       = head.rd;
  assign bus.trace_rd_data_o  = head.rd_data;
  assign bus.trace_mem_wrt_o  = head.mem_wrt;
  assign bus.trace_mem_addr_o = head.mem_addr;
  assign bus.trace_mem_data_o = head.mem_data;

endmodule

// File: tb/tb_rv_retire_trace_sink.sv
// tb/tb_rv_retire_trace_sink.sv - directed self-checking bench for rv_retire_trace_sink
module tb_rv_retire_trace_sink;

  logic        clk;
  logic        rstn;
  logic        clear;
  logic [31:0] retire_count;
  logic [31:0] drop_count;
  logic        overflow;
  int          total;
  int          bad;
  int          exp_ret;

  rv_retire_trace_sink_if #(.XLEN(32)) bus ();

  rv_retire_trace_sink #(
    .XLEN  (32),
    .DEPTH (8),
    .CNT_W (32)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .clear_i        (clear),
    .bus            (bus.slave),
    .retire_count_o (retire_count),
    .drop_count_o   (drop_count),
    .overflow_o     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                        input logic [31:0] data, input logic st, input logic [31:0] addr,
                        input logic [31:0] mdata);
    bus.update_i   = 1'b1;
    bus.pc_i       = pc;
    bus.instr_i    = instr;
    bus.reg_addr_i = rd;
    bus.reg_data_i = data;
    bus.mem_wrt_i  = st;
    bus.mem_addr_i = addr;
    bus.mem_data_i = mdata;
    step();
    bus.update_i  = 1'b0;
    bus.mem_wrt_i = 1'b0;
    exp_ret++;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] mdata);
    bus.mem_wrt_i  = 1'b1;
    bus.mem_addr_i = addr;
    bus.mem_data_i = mdata;
    step();
    bus.mem_wrt_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_ret = 0;
    rstn = 1'b0;
    clear = 1'b0;
    bus.update_i = 1'b0;
    bus.pc_i = '0;
    bus.instr_i = '0;
    bus.reg_addr_i = '0;
    bus.reg_data_i = '0;
    bus.mem_wrt_i = 1'b0;
    bus.mem_addr_i = '0;
    bus.mem_data_i = '0;
    bus.trace_ready_i = 1'b1;
    repeat (3) step();
    check("rst_valid", bus.trace_valid_o, 0);
    check("rst_pc", bus.trace_pc_o, 0);
    check("rst_retire", retire_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ovf", overflow, 0);
    rstn = 1'b1;
    step();

    // single retire
    retire(32'h100, 32'h0050_0093, 5'd1, 32'd5, 1'b0, 0, 0);
    check("t1_valid", bus.trace_valid_o, 1);
    check("t1_pc", bus.trace_pc_o, 32'h100);
    check("t1_instr", bus.trace_instr_o, 32'h0050_0093);
    check("t1_rd", bus.trace_rd_o, 1);
    check("t1_rd_data", bus.trace_rd_data_o, 5);
    check("t1_mem_wrt", bus.trace_mem_wrt_o, 0);
    check("t1_retire", retire_count, 1);
    step();
    check("t1_drained", bus.trace_valid_o, 0);

    // store attached to a later retire
    store(32'h2000, 32'hDEAD);
    step();
    step();
    retire(32'h104, 32'h0000_0013, 5'd2, 32'd7, 1'b0, 0, 0);
    check("t2_mem_wrt", bus.trace_mem_wrt_o, 1);
    check("t2_mem_addr", bus.trace_mem_addr_o, 32'h2000);
    check("t2_mem_data", bus.trace_mem_data_o, 32'hDEAD);
    step();
    retire(32'h108, 32'h0000_0013, 5'd3, 32'd9, 1'b0, 0, 0);
    check("t2_next_wrt", bus.trace_mem_wrt_o, 0);
    check("t2_next_addr", bus.trace_mem_addr_o, 0);
    step();

    // last latched store wins; same-cycle store beats the latch
    store(32'h3000, 32'h1111);
    store(32'h3004, 32'h2222);
    retire(32'h110, 32'h0000_0013, 5'd4, 32'd1, 1'b0, 0, 0);
    check("t3_last_addr", bus.trace_mem_addr_o, 32'h3004);
    check("t3_last_data", bus.trace_mem_data_o, 32'h2222);
    step();
    store(32'h4000, 32'h3333);
    retire(32'h114, 32'h0000_0013, 5'd5, 32'd1, 1'b1, 32'h5000, 32'h4444);
    check("t3_same_addr", bus.trace_mem_addr_o, 32'h5000);
    check("t3_same_data", bus.trace_mem_data_o, 32'h4444);
    step();
    retire(32'h118, 32'h0000_0013, 5'd6, 32'd1, 1'b0, 0, 0);
    check("t3_consumed", bus.trace_mem_wrt_o, 0);
    step();

    // x0 masking
    retire(32'h11C, 32'h0000_0013, 5'd0, 32'h1234, 1'b0, 0, 0);
    check("t4_rd", bus.trace_rd_o, 0);
    check("t4_rd_data", bus.trace_rd_data_o, 0);
    step();

    // overflow with ready low
    bus.trace_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) retire(32'h200 + 32'(4 * i), 32'h13, 5'd1, 32'(i), 1'b0, 0, 0);
    check("t5_drop", drop_count, 2);
    check("t5_ovf", overflow, 1);
    check("t5_retire", retire_count, 32'(exp_ret));
    step();
    step();
    check("t5_hold_pc", bus.trace_pc_o, 32'h200);
    bus.trace_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_drain%0d", i), bus.trace_pc_o, 32'h200 + 32'(4 * i));
      step();
    end
    check("t5_empty", bus.trace_valid_o, 0);

    // full FIFO plus simultaneous pop
    bus.trace_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) retire(32'h300 + 32'(4 * i), 32'h13, 5'd1, 32'(i), 1'b0, 0, 0);
    check("t6_nodrop_fill", drop_count, 2);
    bus.trace_ready_i = 1'b1;
    retire(32'h400, 32'h13, 5'd1, 32'd0, 1'b0, 0, 0);
    bus.trace_ready_i = 1'b0;
    check("t6_nodrop", drop_count, 2);
    check("t6_head", bus.trace_pc_o, 32'h304);
    retire(32'h404, 32'h13, 5'd1, 32'd0, 1'b0, 0, 0);
    check("t6_still_full", drop_count, 3);
    bus.trace_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t6_drain%0d", i), bus.trace_pc_o, 32'h304 + 32'(4 * i));
      step();
    end
    check("t6_tail", bus.trace_pc_o, 32'h400);
    step();
    check("t6_empty", bus.trace_valid_o, 0);

    // clear under backpressure
    bus.trace_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) retire(32'h500 + 32'(4 * i), 32'h13, 5'd7, 32'hAA, 1'b0, 0, 0);
    store(32'h6000, 32'h5555);
    check("t7_stall_pc", bus.trace_pc_o, 32'h500);
    check("t7_stall_rd", bus.trace_rd_data_o, 32'hAA);
    clear = 1'b1;
    retire(32'h600, 32'h13, 5'd1, 32'd1, 1'b1, 32'h7000, 32'h6666);
    clear = 1'b0;
    exp_ret = 0;
    check("t7_valid", bus.trace_valid_o, 0);
    check("t7_retire", retire_count, 0);
    check("t7_drop", drop_count, 0);
    check("t7_ovf", overflow, 0);
    check("t7_pc", bus.trace_pc_o, 0);
    bus.trace_ready_i = 1'b1;
    retire(32'h700, 32'h13, 5'd1, 32'd2, 1'b0, 0, 0);
    check("t7_pend_gone", bus.trace_mem_wrt_o, 0);
    check("t7_retire1", retire_count, 1);
    step();

    // asynchronous reset mid-stream
    bus.trace_ready_i = 1'b0;
    retire(32'h800, 32'h13, 5'd1, 32'd3, 1'b0, 0, 0);
    retire(32'h804, 32'h13, 5'd1, 32'd4, 1'b0, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    check("t8_valid", bus.trace_valid_o, 0);
    check("t8_retire", retire_count, 0);
    check("t8_pc", bus.trace_pc_o, 0);
    step();
    rstn = 1'b1;
    step();
    check("t8_after", bus.trace_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
